uga_dyna_bus_sched: RTL and testbench
=====================================

Name: uga_dyna_bus_sched

Overview:
Round-robin scheduler sharing the single half-duplex Dynamixel TTL bus between N_REQ position-update requesters (one per servo or host channel).
- Grants one requester at a time and latches its servo ID and goal position.
- Launches the downstream instruction-packet sender, then waits for the servo status packet (or timeout) and enforces a bus turnaround gap before the next grant.
- Sits between user/control logic and the packet sender + uga_uart.

Parameters:
N_REQ, 4, number of requesters (2..8)
RX_TIMEOUT, 50000, cycles to wait for a complete status packet after pkt_done (1 ms at 50 MHz)
GAP_CYCLES, 500, idle cycles enforced on the bus after each transaction
STATUS_BYTES, 6, status packet length in bytes (FF FF ID LEN ERR CHK)

Ports:
clk_fpga  in  1  50 MHz clock
rst_n  in  1  reset
req  in  N_REQ  level request per requester; held until done/err pulse
req_id  in  8*N_REQ  servo ID per requester (slice k = [8k+7:8k])
req_pos  in  16*N_REQ  goal position per requester
gnt  out  N_REQ  one-cycle pulse: request accepted, id/pos latched
done  out  N_REQ  one-cycle pulse: transaction completed
err  out  N_REQ  one-cycle pulse coincident with done: timeout or nonzero status error byte
pkt_start  out  1  one-cycle pulse to packet sender
pkt_id  out  8  latched servo ID, stable from grant until return to IDLE
pkt_pos  out  16  latched goal position, same stability
pkt_done  in  1  one-cycle pulse: checksum byte transmitted
rx_valid  in  1  one-cycle pulse per received UART byte
rx_data  in  8  received byte
last_status  out  8  ERR byte of the most recent status packet
busy  out  1  high in any state other than IDLE

Behaviour:
Interface: reset rst_n, asynchronous, active-low; clock clk_fpga. All logic is rising-edge.

Reset values:
- State IDLE; round-robin pointer 0.
- gnt, done, err, pkt_start, busy = 0; pkt_id, pkt_pos, last_status = 0.
- Reset mid-transaction aborts immediately; no done/err is emitted.

States: IDLE, GRANT, LAUNCH, WAIT_TX, WAIT_RX, GAP.
- IDLE: if any req bit is set, select the first set bit scanning from ptr upward mod N_REQ -> GRANT.
- GRANT: gnt[k] pulses 1 cycle; latch req_id[k] and req_pos[k] -> LAUNCH.
- LAUNCH: pkt_start pulses 1 cycle -> WAIT_TX.
- WAIT_TX: stay until pkt_done. Then, if pkt_id == 8'hFE (broadcast, no reply): done[k] pulses, -> GAP. Otherwise clear byte counter and timer -> WAIT_RX.
- WAIT_RX: each rx_valid increments the byte counter. Byte index 4 (the 5th byte) is stored in last_status.
  - Counter reaches STATUS_BYTES: done[k] pulses; err[k] also pulses if last_status != 0; -> GAP.
  - Timer reaches RX_TIMEOUT-1 first: done[k] and err[k] pulse; last_status is unchanged; -> GAP.
  - Final byte and timeout in the same cycle: the byte wins (treated as completion).
- GAP: count GAP_CYCLES cycles, then -> IDLE. Set ptr = (k+1) mod N_REQ on GAP entry.

Boundary rules:
- Grant-to-pkt_start latency is exactly 1 cycle.
- rx_valid outside WAIT_RX is ignored; the sender's echoed TX bytes are never counted.
- req changes after grant have no effect on the latched data.
- A deasserted req is skipped by the scan.
- Counters saturate and never wrap.
- Timer width is $clog2(RX_TIMEOUT+1).

Optional Feature:
Macro DYNA_RETRY_EN.
- Defined: on the first timeout of a transaction, pulse pkt_start again (via LAUNCH, without a new gnt) and restart WAIT_TX. A second timeout produces done+err. Retry count resets at each grant.
- Undefined: the first timeout produces done+err directly.

Test Plan:
1. req=4'b0001, id=0x02, pos=0x0700; pkt_done 20 cycles after pkt_start; 6 rx bytes with ERR=0x00 -> gnt[0], pkt_start 1 cycle later, pkt_id=0x02, pkt_pos=0x0700, done[0], err=0, then busy low after 500 gap cycles.
2. req=4'b1111 held for 4 transactions -> grant order 0,1,2,3; then ptr=0 again.
3. id=0xFE broadcast -> done at pkt_done with no WAIT_RX; rx bytes during GAP are ignored.
4. No rx bytes after pkt_done -> done+err exactly 50000 cycles later. With DYNA_RETRY_EN: second pkt_start, and err only after the second timeout.
5. Status packet with ERR byte 0x20 -> last_status=0x20, done+err pulse together.
6. Assert rst_n=0 during WAIT_RX -> all outputs 0 asynchronously; after release, IDLE with ptr 0 and no done emitted.

Source files
------------

// File: rtl/uga_dyna_bus_sched.sv
// uga_dyna_bus_sched: round-robin scheduler for the shared half-duplex Dynamixel bus (optional retry: DYNA_RETRY_EN)
module uga_dyna_bus_sched #(
    parameter int N_REQ        = 4,
    parameter int RX_TIMEOUT   = 50000,
    parameter int GAP_CYCLES   = 500,
    parameter int STATUS_BYTES = 6
) (
    input  logic                 clk_fpga,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_id,
    input  logic [16*N_REQ-1:0]  req_pos,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     done,
    output logic [N_REQ-1:0]     err,
    output logic                 pkt_start,
    output logic [7:0]           pkt_id,
    output logic [15:0]          pkt_pos,
    input  logic                 pkt_done,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    output logic [7:0]           last_status,
    output logic                 busy
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(RX_TIMEOUT + 1);
    localparam int CW = $clog2(STATUS_BYTES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GRANT   = 3'd1;
    localparam logic [2:0] S_LAUNCH  = 3'd2;
    localparam logic [2:0] S_WAIT_TX = 3'd3;
    localparam logic [2:0] S_WAIT_RX = 3'd4;
    localparam logic [2:0] S_GAP     = 3'd5;

    logic [2:0]       state;
    logic [IW-1:0]    ptr, k, sel, ptr_nxt;
    logic             found;
    logic [TW-1:0]    timer;
    logic [CW-1:0]    cnt;
    logic [GW-1:0]    gap_cnt;
    logic [N_REQ-1:0] k_oh;
    logic             rx_last, rx_err_byte, tmo;
    logic [7:0]       st_val;
`ifdef DYNA_RETRY_EN
    logic             retry;
`endif

    // first pending request at or after ptr, wrapping around
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[(int'(ptr) + i) % N_REQ]) begin
                found = 1'b1;
                sel   = IW'((int'(ptr) + i) % N_REQ);
            end
        end
    end

    assign k_oh        = {{(N_REQ-1){1'b0}}, 1'b1} << k;
    assign ptr_nxt     = (k == IW'(N_REQ - 1)) ? '0 : k + 1'b1;
    assign gnt         = (state == S_GRANT) ? k_oh : '0;
    assign pkt_start   = state == S_LAUNCH;
    assign busy        = state != S_IDLE;
    assign rx_last     = rx_valid && cnt == CW'(STATUS_BYTES - 1);
    assign rx_err_byte = rx_valid && cnt == CW'(4);
    assign st_val      = rx_err_byte ? rx_data : last_status;
    assign tmo         = timer == TW'(RX_TIMEOUT - 1);

    // transaction sequencer; a completing byte takes priority over a same-cycle timeout
    always_ff @(posedge clk_fpga or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ptr         <= '0;
            k           <= '0;
            timer       <= '0;
            cnt         <= '0;
            gap_cnt     <= '0;
            done        <= '0;
            err         <= '0;
            pkt_id      <= '0;
            pkt_pos     <= '0;
            last_status <= '0;
`ifdef DYNA_RETRY_EN
            retry       <= 1'b0;
`endif
        end else begin
            done <= '0;
            err  <= '0;
            case (state)
                S_IDLE: if (found) begin
                    k       <= sel;
                    pkt_id  <= req_id[8*sel +: 8];
                    pkt_pos <= req_pos[16*sel +: 16];
                    state   <= S_GRANT;
`ifdef DYNA_RETRY_EN
                    retry   <= 1'b0;
`endif
                end
                S_GRANT:  state <= S_LAUNCH;
                S_LAUNCH: state <= S_WAIT_TX;
                S_WAIT_TX: if (pkt_done) begin
                    if (pkt_id == 8'hFE) begin
                        done    <= k_oh;
                        ptr     <= ptr_nxt;
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end else begin
                        cnt   <= '0;
                        timer <= '0;
                        state <= S_WAIT_RX;
                    end
                end
                S_WAIT_RX: begin
                    if (rx_valid && cnt != CW'(STATUS_BYTES)) cnt <= cnt + 1'b1;
                    if (rx_err_byte) last_status <= rx_data;
                    if (rx_last) begin
                        done    <= k_oh;
                        err     <= |st_val ? k_oh : '0;
                        ptr     <= ptr_nxt;
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end
`ifdef DYNA_RETRY_EN
                    else if (tmo && !retry) begin
                        retry <= 1'b1;
                        state <= S_LAUNCH;
                    end
`endif
                    else if (tmo) begin
                        done    <= k_oh;
                        err     <= k_oh;
                        ptr     <= ptr_nxt;
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end else if (timer != TW'(RX_TIMEOUT)) timer <= timer + 1'b1;
                end
                S_GAP: if (gap_cnt >= GW'(GAP_CYCLES - 1)) state <= S_IDLE;
                       else gap_cnt <= gap_cnt + 1'b1;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uga_dyna_bus_sched.sv
// tb_uga_dyna_bus_sched: directed self-checking bench for the Dynamixel bus scheduler
module tb_uga_dyna_bus_sched;
    localparam int RXT = 200;
    localparam int GAP = 16;
`ifdef DYNA_RETRY_EN
    localparam int TO_LAT    = 2*RXT + 3;
    localparam int TO_STARTS = 2;
`else
    localparam int TO_LAT    = RXT + 1;
    localparam int TO_STARTS = 1;
`endif

    logic        clk_fpga = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_id;
    logic [63:0] req_pos;
    logic [3:0]  gnt, done, err;
    logic        pkt_start, pkt_done, rx_valid, busy;
    logic [7:0]  pkt_id, rx_data, last_status;
    logic [15:0] pkt_pos;
    int n_checks = 0;
    int n_errors = 0;

    uga_dyna_bus_sched #(.N_REQ(4), .RX_TIMEOUT(RXT), .GAP_CYCLES(GAP), .STATUS_BYTES(6)) dut (
        .clk_fpga(clk_fpga), .rst_n(rst_n), .req(req), .req_id(req_id), .req_pos(req_pos),
        .gnt(gnt), .done(done), .err(err), .pkt_start(pkt_start), .pkt_id(pkt_id), .pkt_pos(pkt_pos),
        .pkt_done(pkt_done), .rx_valid(rx_valid), .rx_data(rx_data), .last_status(last_status), .busy(busy)
    );

    always #5 clk_fpga = ~clk_fpga;

    // full transaction: wait grant, echo bytes during WAIT_TX, pkt_done, then n_rx status bytes
    task automatic do_txn(input int n_rx, input logic [7:0] errb,
                          output logic [3:0] g, output logic sp, output logic [7:0] gid, output logic [15:0] gpos,
                          output int lat, output logic [3:0] d, output logic [3:0] e, output int starts,
                          output logic [7:0] did, output logic [15:0] dpos);
        logic [7:0] pk [6];
        logic [7:0] echo [6];
        logic [31:0] sid;
        logic [63:0] spos;
        logic sp_prev;
        g = '0; sp = 0; gid = '0; gpos = '0; lat = -1; d = '0; e = '0; starts = 0; did = '0; dpos = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_fpga);
            if (gnt != 0) begin g = gnt; gid = pkt_id; gpos = pkt_pos; break; end
        end
        if (g == 0) return;
        pk = '{8'hFF, 8'hFF, gid, 8'h02, errb, ~(gid + 8'h02 + errb)};
        echo = '{8'hFF, 8'hFF, 8'h01, 8'h04, 8'h77, 8'h80};
        sid = req_id; spos = req_pos;
        req_id = ~req_id; req_pos = ~req_pos;
        @(negedge clk_fpga);
        sp = pkt_start;
        starts = int'(pkt_start);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_fpga);
            rx_valid = (i < 12) && (i % 2 == 0);
            rx_data = echo[(i / 2) % 6];
        end
        rx_valid = 0;
        pkt_done = 1;
        sp_prev = 0;
        for (int c = 1; c <= 2*RXT + 40; c++) begin
            @(negedge clk_fpga);
            pkt_done = sp_prev;
            rx_valid = 0;
            if (done != 0) begin lat = c; d = done; e = err; did = pkt_id; dpos = pkt_pos; break; end
            sp_prev = pkt_start;
            starts += int'(pkt_start);
            if (c % 2 == 0 && c / 2 <= n_rx) begin rx_valid = 1; rx_data = pk[c/2 - 1]; end
        end
        pkt_done = 0; rx_valid = 0;
        req_id = sid; req_pos = spos;
    endtask

    task automatic wait_idle(output int k);
        k = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk_fpga);
            if (!busy) begin k = i; break; end
        end
    endtask

    task automatic test_reset;
        rst_n = 0; req = 4'b0001; req_id = 32'h0; req_pos = 64'h0;
        pkt_done = 0; rx_valid = 0; rx_data = 0;
        repeat (3) @(negedge clk_fpga);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (gnt !== 4'b0) begin n_errors++; $display("FAIL reset_gnt got %b want 0000", gnt); end
        n_checks++; if ({done, err, pkt_start} !== 9'b0) begin n_errors++; $display("FAIL reset_pulses got %b want 0", {done, err, pkt_start}); end
        n_checks++; if ({pkt_id, pkt_pos, last_status} !== 32'h0) begin n_errors++; $display("FAIL reset_data got %h want 0", {pkt_id, pkt_pos, last_status}); end
        req = 4'b0000;
        rst_n = 1;
        @(negedge clk_fpga);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_basic;
        logic [3:0] g, d, e; logic sp; logic [7:0] gid, did; logic [15:0] gpos, dpos; int lat, st, k;
        req_id[7:0] = 8'h02; req_pos[15:0] = 16'h0700; req = 4'b0001;
        do_txn(6, 8'h00, g, sp, gid, gpos, lat, d, e, st, did, dpos);
        req = 4'b0000;
        n_checks++; if (g !== 4'b0001) begin n_errors++; $display("FAIL basic_gnt got %b want 0001", g); end
        n_checks++; if (sp !== 1'b1) begin n_errors++; $display("FAIL basic_start_latency got %b want 1", sp); end
        n_checks++; if (gid !== 8'h02 || gpos !== 16'h0700) begin n_errors++; $display("FAIL basic_latch got %h/%h want 02/0700", gid, gpos); end
        n_checks++; if (did !== 8'h02 || dpos !== 16'h0700) begin n_errors++; $display("FAIL basic_hold got %h/%h want 02/0700", did, dpos); end
        n_checks++; if (lat !== 13) begin n_errors++; $display("FAIL basic_done_latency got %0d want 13", lat); end
        n_checks++; if (d !== 4'b0001 || e !== 4'b0000) begin n_errors++; $display("FAIL basic_done_err got %b/%b want 0001/0000", d, e); end
        n_checks++; if (st !== 1) begin n_errors++; $display("FAIL basic_starts got %0d want 1", st); end
        n_checks++; if (last_status !== 8'h00) begin n_errors++; $display("FAIL basic_echo_ignored got %h want 00", last_status); end
        wait_idle(k);
        n_checks++; if (k !== GAP) begin n_errors++; $display("FAIL basic_gap got %0d want %0d", k, GAP); end
    endtask

    task automatic test_error;
        logic [3:0] g, d, e; logic sp; logic [7:0] gid, did; logic [15:0] gpos, dpos; int lat, st, k;
        req_id[7:0] = 8'h05; req_pos[15:0] = 16'h0123; req = 4'b0001;
        do_txn(6, 8'h20, g, sp, gid, gpos, lat, d, e, st, did, dpos);
        req = 4'b0000;
        n_checks++; if (d !== 4'b0001 || e !== 4'b0001) begin n_errors++; $display("FAIL error_done_err got %b/%b want 0001/0001", d, e); end
        n_checks++; if (last_status !== 8'h20) begin n_errors++; $display("FAIL error_status got %h want 20", last_status); end
        n_checks++; if (lat !== 13) begin n_errors++; $display("FAIL error_latency got %0d want 13", lat); end
        wait_idle(k);
    endtask

    task automatic test_broadcast;
        logic [3:0] g, d, e, acc; logic sp; logic [7:0] gid, did; logic [15:0] gpos, dpos; int lat, st, k;
        req_id[23:16] = 8'hFE; req_pos[47:32] = 16'h0200; req = 4'b0100;
        do_txn(6, 8'h00, g, sp, gid, gpos, lat, d, e, st, did, dpos);
        req = 4'b0000;
        n_checks++; if (g !== 4'b0100) begin n_errors++; $display("FAIL bcast_gnt got %b want 0100", g); end
        n_checks++; if (lat !== 1 || d !== 4'b0100 || e !== 4'b0000) begin n_errors++; $display("FAIL bcast_done got lat=%0d %b/%b want 1 0100/0000", lat, d, e); end
        acc = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_fpga);
            acc |= done | err;
            rx_valid = (i % 2 == 0); rx_data = (i == 8) ? 8'h55 : 8'hFF;
        end
        rx_valid = 0;
        n_checks++; if (acc !== 4'b0 || last_status !== 8'h20) begin n_errors++; $display("FAIL bcast_gap_rx got done=%b status=%h want 0000/20", acc, last_status); end
        wait_idle(k);
    endtask

    task automatic test_timeout;
        logic [3:0] g, d, e; logic sp; logic [7:0] gid, did; logic [15:0] gpos, dpos; int lat, st, k;
        req_id[31:24] = 8'h07; req_pos[63:48] = 16'h0333; req = 4'b1000;
        do_txn(0, 8'h00, g, sp, gid, gpos, lat, d, e, st, did, dpos);
        req = 4'b0000;
        n_checks++; if (lat !== TO_LAT) begin n_errors++; $display("FAIL timeout_latency got %0d want %0d", lat, TO_LAT); end
        n_checks++; if (d !== 4'b1000 || e !== 4'b1000) begin n_errors++; $display("FAIL timeout_done_err got %b/%b want 1000/1000", d, e); end
        n_checks++; if (st !== TO_STARTS) begin n_errors++; $display("FAIL timeout_starts got %0d want %0d", st, TO_STARTS); end
        n_checks++; if (last_status !== 8'h20) begin n_errors++; $display("FAIL timeout_status got %h want 20", last_status); end
        wait_idle(k);
    endtask

    task automatic test_round_robin;
        logic [3:0] g, d, e; logic sp; logic [7:0] gid, did; logic [15:0] gpos, dpos; int lat, st;
        rst_n = 0; @(negedge clk_fpga); rst_n = 1;
        req_id = 32'h13121110; req_pos = 64'h0403_0302_0201_0100; req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            do_txn(6, 8'h00, g, sp, gid, gpos, lat, d, e, st, did, dpos);
            n_checks++; if (g !== (4'b0001 << (i % 4)) || gid !== 8'h10 + 8'(i % 4)) begin n_errors++; $display("FAIL rr_order_%0d got %b/%h want %b/%h", i, g, gid, 4'b0001 << (i % 4), 8'h10 + 8'(i % 4)); end
            n_checks++; if (d !== g || e !== 4'b0) begin n_errors++; $display("FAIL rr_done_%0d got %b/%b want %b/0000", i, d, e, g); end
        end
        req = 4'b0000;
        wait_idle(st);
    endtask

    task automatic test_skip;
        logic [3:0] g, d, e; logic sp; logic [7:0] gid, did; logic [15:0] gpos, dpos; int lat, st;
        rst_n = 0; @(negedge clk_fpga); rst_n = 1;
        req = 4'b1010;
        do_txn(6, 8'h00, g, sp, gid, gpos, lat, d, e, st, did, dpos);
        n_checks++; if (g !== 4'b0010) begin n_errors++; $display("FAIL skip_first got %b want 0010", g); end
        do_txn(6, 8'h00, g, sp, gid, gpos, lat, d, e, st, did, dpos);
        n_checks++; if (g !== 4'b1000) begin n_errors++; $display("FAIL skip_second got %b want 1000", g); end
        req = 4'b0000;
        wait_idle(st);
    endtask

    task automatic test_reset_mid;
        logic [3:0] g, d, e, acc; logic sp, bacc; logic [7:0] gid, did; logic [15:0] gpos, dpos; int lat, st;
        req = 4'b0010;
        do_txn(6, 8'h00, g, sp, gid, gpos, lat, d, e, st, did, dpos);
        req = 4'b0000;
        wait_idle(st);
        req_id[23:16] = 8'h09; req_pos[47:32] = 16'h0999; req = 4'b0100;
        g = '0;
        for (int i = 0; i < 60; i++) begin @(negedge clk_fpga); if (gnt != 0) begin g = gnt; break; end end
        n_checks++; if (g !== 4'b0100) begin n_errors++; $display("FAIL mid_gnt got %b want 0100", g); end
        repeat (3) @(negedge clk_fpga);
        pkt_done = 1; @(negedge clk_fpga); pkt_done = 0;
        for (int i = 0; i < 6; i++) begin rx_valid = (i % 2 == 0); rx_data = 8'hFF; @(negedge clk_fpga); end
        rx_valid = 0;
        n_checks++; if (busy !== 1'b1 || pkt_id !== 8'h09) begin n_errors++; $display("FAIL mid_active got busy=%b id=%h want 1/09", busy, pkt_id); end
        #2 rst_n = 0;
        #1;
        n_checks++; if ({busy, gnt, done, err, pkt_start} !== 14'b0) begin n_errors++; $display("FAIL mid_async_ctrl got %b want 0", {busy, gnt, done, err, pkt_start}); end
        n_checks++; if ({pkt_id, pkt_pos, last_status} !== 32'h0) begin n_errors++; $display("FAIL mid_async_data got %h want 0", {pkt_id, pkt_pos, last_status}); end
        req = 4'b0000;
        repeat (2) @(negedge clk_fpga);
        rst_n = 1;
        acc = '0; bacc = 0;
        for (int i = 0; i < 30; i++) begin @(negedge clk_fpga); acc |= done | err; bacc |= busy; end
        n_checks++; if (acc !== 4'b0 || bacc !== 1'b0) begin n_errors++; $display("FAIL mid_no_done got %b busy=%b want 0000/0", acc, bacc); end
        req = 4'b0011;
        do_txn(6, 8'h00, g, sp, gid, gpos, lat, d, e, st, did, dpos);
        req = 4'b0000;
        n_checks++; if (g !== 4'b0001) begin n_errors++; $display("FAIL mid_ptr_reset got %b want 0001", g); end
        wait_idle(st);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_error;
        test_broadcast;
        test_timeout;
        test_round_robin;
        test_skip;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
